// File: rtl/adder_bist_checker.sv
// ============================================================================
// Module   : adder_bist_checker
// Purpose  : Exhaustive {ci,a,b} sweep generator and response checker for a
//            WIDTH-bit adder with LATENCY clocks of pipeline delay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_bist_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               ci_o,
  input  logic [WIDTH-1:0]   s_i,
  input  logic               co_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_cnt,
  output logic [2*WIDTH:0]   first_fail
);

  localparam int VW = 2*WIDTH+1;
  localparam logic [VW-1:0] C_VEC_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [VW-1:0]   r_vec;
  logic [2:0]      r_dcnt;
  logic [15:0]     r_err;
  logic [VW-1:0]   r_ff;

  logic            w_last;
  logic            w_run;
  logic            w_drain_end;
  logic [WIDTH:0]  w_exp;
  logic            w_chk_v;
  logic [WIDTH:0]  w_chk_exp;
  logic [VW-1:0]   w_chk_tag;

  assign w_last      = &r_vec;
  assign w_run       = (r_state == S_RUN);
  assign w_drain_end = (r_dcnt == 3'(LATENCY-1));
  assign w_exp       = {1'b0, r_vec[2*WIDTH-1:WIDTH]} + {1'b0, r_vec[WIDTH-1:0]}
                     + {{WIDTH{1'b0}}, r_vec[VW-1]};

  // Golden result and its tag ride alongside the DUT's own pipeline.
  generate
    if (LATENCY == 0) begin : g_comb
      assign w_chk_v   = w_run;
      assign w_chk_exp = w_exp;
      assign w_chk_tag = r_vec;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_pv;
      logic [WIDTH:0]     r_pexp [LATENCY];
      logic [VW-1:0]      r_ptag [LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pv <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            r_pexp[i] <= '0;
            r_ptag[i] <= '0;
          end
        end else begin
          r_pv[0]   <= w_run;
          r_pexp[0] <= w_exp;
          r_ptag[0] <= r_vec;
          for (int i = 1; i < LATENCY; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_pexp[i] <= r_pexp[i-1];
            r_ptag[i] <= r_ptag[i-1];
          end
        end
      end

      assign w_chk_v   = r_pv[LATENCY-1];
      assign w_chk_exp = r_pexp[LATENCY-1];
      assign w_chk_tag = r_ptag[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN:          if (w_last) w_next = (LATENCY == 0) ? S_DONE : S_DRAIN;
      S_DRAIN:        if (w_drain_end) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= '0;
      r_dcnt <= '0;
      r_err  <= '0;
      r_ff   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_vec <= '0;
            r_err <= '0;
            r_ff  <= '0;
          end
        end
        S_RUN: begin
          r_dcnt <= '0;
          // Hold the final vector through drain so it is never wrapped to 0.
          if (!w_last)           r_vec <= r_vec + C_VEC_ONE;
          else if (LATENCY == 0) r_vec <= '0;
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + 3'd1;
          if (w_drain_end) r_vec <= '0;
        end
        default: ;
      endcase

      if (w_chk_v && ({co_i, s_i} != w_chk_exp)) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0)    r_ff  <= w_chk_tag;
      end
    end
  end

  assign {ci_o, a_o, b_o} = r_vec;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_err == 16'd0);
  assign err_cnt    = r_err;
  assign first_fail = r_ff;

endmodule

`default_nettype wire

// File: tb/tb_adder_bist_checker.sv
// ============================================================================
// Module   : tb_adder_bist_checker
// Purpose  : Fault-table and randomized-fault bench for adder_bist_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_bist_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: combinational adder, instance 2: two-stage registered adder
  logic       start0 = 1'b0, start2 = 1'b0;
  logic [3:0] a0, b0, s0, a2, b2, s2;
  logic       ci0, co0, ci2, co2;
  logic       busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] err0, err2;
  logic [8:0]  ff0, ff2;

  int fmode0 = 0, fmode2 = 0;
  bit       bad  [512];
  bit [4:0] mask [512];

  adder_bist_checker #(.WIDTH(4), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a_o(a0), .b_o(b0), .ci_o(ci0),
    .s_i(s0), .co_i(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail(ff0));

  adder_bist_checker #(.WIDTH(4), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .ci_o(ci2),
    .s_i(s2), .co_i(co2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail(ff2));

  function automatic bit [4:0] true_sum(input int v);
    return 5'((v >> 4) % 16 + v % 16 + v / 256);
  endfunction

  function automatic bit [4:0] adder(input int v, input int mode);
    bit [4:0] r;
    r = true_sum(v);
    case (mode)
      1: r[3] = 1'b0;
      2: r[4] = 1'b1;
      3: r[0] = 1'b1;
      4: r[4] = 1'b0;
      5: if (bad[v]) r = r ^ mask[v];
      default: ;
    endcase
    return r;
  endfunction

  always_comb {co0, s0} = adder(int'({ci0, a0, b0}), fmode0);

  logic [4:0] p1, p2;
  always_ff @(posedge clk) begin
    p1 <= adder(int'({ci2, a2, b2}), fmode2);
    p2 <= p1;
  end
  assign {co2, s2} = p2;

  // reference: mismatch count and first failing vector over vectors [0,lim)
  task automatic model(input int mode, input int lim, output int cnt, output int ff);
    cnt = 0; ff = 0;
    for (int v = 0; v < lim; v++)
      if (adder(v, mode) != true_sum(v)) begin
        if (cnt == 0) ff = v;
        cnt++;
      end
  endtask

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, expv);
  endtask

  int  cur_sel = 0;
  logic [8:0] m_vec;
  logic       m_busy, m_done, m_pass;
  logic [15:0] m_err;
  logic [8:0]  m_ff;
  assign m_vec  = cur_sel == 0 ? {ci0, a0, b0} : {ci2, a2, b2};
  assign m_busy = cur_sel == 0 ? busy0 : busy2;
  assign m_done = cur_sel == 0 ? done0 : done2;
  assign m_pass = cur_sel == 0 ? pass0 : pass2;
  assign m_err  = cur_sel == 0 ? err0 : err2;
  assign m_ff   = cur_sel == 0 ? ff0 : ff2;

  task automatic set_start(input logic v);
    if (cur_sel == 0) start0 = v; else start2 = v;
  endtask

  // start a sweep, optionally re-pulse start at cycle repulse_at, run to completion
  task automatic sweep(input int repulse_at, output int ncyc, output int seq_err);
    int n, ev;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    chk("start_busy", int'(m_busy), 1);
    chk("start_clear", int'({m_done, m_pass}) + int'(m_err) + int'(m_ff), 0);
    n = 0; seq_err = 0;
    while (m_busy && n < 3000) begin
      ev = n > 511 ? 511 : n;
      if (int'(m_vec) != ev) seq_err++;
      set_start(n == repulse_at);
      @(negedge clk);
      n++;
    end
    set_start(1'b0);
    ncyc = n;
  endtask

  typedef struct {
    int mode;
    int exp_err;
    int exp_ff;
    int exp_pass;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int ncyc, serr, cnt, ffm, rp;
    tbl[0] = '{0,   0, 9'h000, 1};
    tbl[1] = '{1, 256, 9'h008, 0};
    tbl[2] = '{2, 256, 9'h000, 0};
    tbl[3] = '{3, 256, 9'h000, 0};
    tbl[4] = '{4, 256, 9'h01F, 0};

    repeat (3) @(negedge clk);
    chk("reset_outs", int'({a0, b0, ci0, busy0, done0, pass0}) + int'(err0) + int'(ff0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", int'({a0, b0, ci0, busy0, done0, pass0}), 0);

    cur_sel = 0;
    for (int i = 0; i < 5; i++) begin
      fmode0 = tbl[i].mode;
      sweep(-1, ncyc, serr);
      chk($sformatf("t%0d_busy_cycles", i), ncyc, 512);
      chk($sformatf("t%0d_vec_seq", i), serr, 0);
      chk($sformatf("t%0d_done", i), int'(m_done), 1);
      chk($sformatf("t%0d_pass", i), int'(m_pass), tbl[i].exp_pass);
      chk($sformatf("t%0d_err_cnt", i), int'(m_err), tbl[i].exp_err);
      chk($sformatf("t%0d_first_fail", i), int'(m_ff), tbl[i].exp_ff);
      chk($sformatf("t%0d_outs_zero", i), int'({a0, b0, ci0}), 0);
    end

    // two-stage DUT
    cur_sel = 1; fmode2 = 0;
    sweep(-1, ncyc, serr);
    chk("lat2_busy_cycles", ncyc, 514);
    chk("lat2_vec_seq", serr, 0);
    chk("lat2_pass", int'({m_done, m_pass}), 3);
    chk("lat2_err_cnt", int'(m_err), 0);
    fmode2 = 1;
    sweep(-1, ncyc, serr);
    chk("lat2_s3_err", int'(m_err), 256);
    chk("lat2_s3_ff", int'(m_ff), 9'h008);

    // reset mid-sweep
    cur_sel = 0; fmode0 = 1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (100) @(negedge clk);
    model(1, 100, cnt, ffm);
    chk("rst_pre_vec", int'({ci0, a0, b0}), 100);
    chk("rst_pre_err", int'(err0), cnt);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_ab", int'({a0, b0, ci0, done0}) + int'(ff0), 0);
    repeat (4) @(negedge clk);
    chk("rst_no_stale", int'(err0), 0);
    fmode0 = 0;
    sweep(-1, ncyc, serr);
    chk("rst_fresh_cycles", ncyc, 512);
    chk("rst_fresh_pass", int'(pass0), 1);

    // start re-pulsed while busy, then start from DONE
    fmode0 = 1;
    sweep(50, ncyc, serr);
    chk("repulse_cycles", ncyc, 512);
    chk("repulse_err", int'(err0), 256);
    repeat (5) @(negedge clk);
    chk("done_held", int'(done0), 1);
    fmode0 = 0;
    sweep(-1, ncyc, serr);
    chk("restart_cycles", ncyc, 512);
    chk("restart_pass", int'({done0, pass0}), 3);

    // randomized fault patterns against the reference model
    for (int it = 0; it < 4; it++) begin
      for (int v = 0; v < 512; v++) begin
        bad[v]  = ($urandom_range(0, 15) == 0);
        mask[v] = 5'($urandom_range(1, 31));
      end
      model(5, 512, cnt, ffm);
      rp = int'($urandom_range(0, 520));
      cur_sel = it % 2;
      fmode0 = 5; fmode2 = 5;
      sweep(rp, ncyc, serr);
      chk($sformatf("rnd%0d_cycles", it), ncyc, cur_sel == 0 ? 512 : 514);
      chk($sformatf("rnd%0d_seq", it), serr, 0);
      chk($sformatf("rnd%0d_err", it), int'(m_err), cnt);
      chk($sformatf("rnd%0d_ff", it), int'(m_ff), ffm);
      chk($sformatf("rnd%0d_pass", it), int'(m_pass), cnt == 0 ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
